// File: rtl/cdc_hs_pkg.sv
// rtl/cdc_hs_pkg.sv - shared states, constants and helpers for the handshake arbiter
package cdc_hs_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 1024;

    // ST_DRAIN is only reachable when the timeout feature is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_REQ_HI = 3'd2,
        ST_REQ_LO = 3'd3,
        ST_DONE   = 3'd4,
        ST_DRAIN  = 3'd5
    } state_e;

    // Number of bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin select from a request vector and pointer
//
// Ports:
//   req_i   in  N   request vector
//   ptr_i   in  IW  highest-priority position; search runs upward and wraps
//   gnt_o   out N   one-hot winner (all zero when no request)
//   idx_o   out IW  index of the winner
//   valid_o out 1   any request present
module rr_arbiter
    import cdc_hs_pkg::*;
#(
    parameter  int N  = DEF_NUM_REQ,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        int c;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        c       = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr_i) + i;
            if (c >= N) begin
                c = c - N;
            end
            if (!valid_o && req_i[c]) begin
                valid_o  = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/cdc_handshake_arbiter.sv
// rtl/cdc_handshake_arbiter.sv - round-robin sharing of one 4-phase req/ack crossing channel
//
// Optional feature macro: CDC_HS_TIMEOUT_EN (ack timeout with DRAIN state).
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   req_i        in   per-requester request level, held until its gnt_o
//   req_data_i   in   payloads, requester k at [k*DATA_W +: DATA_W]
//   gnt_o        out  one-cycle one-hot completion pulse
//   busy_o       out  state is not IDLE
//   xfer_req_o   out  registered crossing request level
//   xfer_data_o  out  registered payload of the requester being served
//   xfer_src_o   out  index of the requester being served
//   xfer_ack_i   in   destination acknowledge, already synchronized
//   timeout_o    out  one-cycle pulse when an ack never arrives (0 without feature)
module cdc_handshake_arbiter
    import cdc_hs_pkg::*;
#(
    parameter  int NUM_REQ     = DEF_NUM_REQ,
    parameter  int DATA_W      = DEF_DATA_W,
    parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int SW          = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic                      busy_o,
    output logic                      xfer_req_o,
    output logic [DATA_W-1:0]         xfer_data_o,
    output logic [SW-1:0]             xfer_src_o,
    input  logic                      xfer_ack_i,
    output logic                      timeout_o
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("cdc_handshake_arbiter: parameter out of range");
    end

    state_e              state_q, state_d;
    logic [SW-1:0]       ptr_q, ptr_d;
    logic                xfer_req_q, xfer_req_d;
    logic [DATA_W-1:0]   xfer_data_q, xfer_data_d;
    logic [SW-1:0]       xfer_src_q, xfer_src_d;
    logic [SW-1:0]       next_ptr;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [SW-1:0]       arb_idx;
    logic                arb_valid;
    logic [DATA_W-1:0]   arb_data;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // One-hot AND-OR mux of the winner's payload.
    always_comb begin
        arb_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_data = arb_data | (req_data_i[k*DATA_W +: DATA_W] & {DATA_W{arb_gnt[k]}});
        end
    end

    // Pointer moves past the requester just served (or just abandoned).
    always_comb begin
        if (xfer_src_q == SW'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = xfer_src_q + SW'(1);
        end
    end

`ifdef CDC_HS_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        xfer_data_d = xfer_data_q;
        xfer_src_d  = xfer_src_q;
`ifdef CDC_HS_TIMEOUT_EN
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A high ack here is left over from an earlier handshake; wait it out.
                if (arb_valid && !xfer_ack_i) begin
                    state_d     = ST_SETUP;
                    xfer_data_d = arb_data;
                    xfer_src_d  = arb_idx;
                end
            end
            ST_SETUP: begin
                // Ack is deliberately not looked at: data settles one cycle before req.
                state_d = ST_REQ_HI;
            end
            ST_REQ_HI: begin
                if (xfer_ack_i) begin
                    state_d = ST_REQ_LO;
                end
`ifdef CDC_HS_TIMEOUT_EN
                else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d   = ST_DRAIN;
                    timeout_d = 1'b1;
                    ptr_d     = next_ptr;
                end
`endif
            end
            ST_REQ_LO: begin
                if (!xfer_ack_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ptr_d   = next_ptr;
                state_d = ST_IDLE;
            end
`ifdef CDC_HS_TIMEOUT_EN
            ST_DRAIN: begin
                if (!xfer_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        xfer_req_d = (state_d == ST_REQ_HI);
    end

`ifdef CDC_HS_TIMEOUT_EN
    // Runs only while staying in REQ_HI; any state entry restarts it at zero.
    always_comb begin
        if (state_q == ST_REQ_HI && state_d == ST_REQ_HI) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end else begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            xfer_req_q  <= 1'b0;
            xfer_data_q <= '0;
            xfer_src_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            xfer_req_q  <= xfer_req_d;
            xfer_data_q <= xfer_data_d;
            xfer_src_q  <= xfer_src_d;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (state_q == ST_DONE) begin
            gnt_o[xfer_src_q] = 1'b1;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign xfer_req_o  = xfer_req_q;
    assign xfer_data_o = xfer_data_q;
    assign xfer_src_o  = xfer_src_q;

endmodule

// File: doc/cdc_handshake_arbiter.md
Name: cdc_handshake_arbiter

Overview:
- Source-domain controller that shares one 4-phase req/ack clock-crossing channel among NUM_REQ requesters.
- Round-robin arbitrates requests, registers the winner's payload, drives the crossing request level and waits for the returned acknowledge.
- The acknowledge is already synchronized into this domain by a two-flop synchronizer outside this block. The block pulses a per-requester grant when the handshake completes.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 8, payload width per requester.
- TIMEOUT_CYC, 1024, ack wait limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester request level; held until the matching gnt_o.
- req_data_i  in  NUM_REQ*DATA_W  payloads; requester k occupies bits [k*DATA_W +: DATA_W].
- gnt_o  out  NUM_REQ  one-cycle completion pulse, one-hot.
- busy_o  out  1  high whenever the state is not IDLE.
- xfer_req_o  out  1  crossing request level, registered.
- xfer_data_o  out  DATA_W  registered payload; stable while xfer_req_o is high.
- xfer_src_o  out  clog2(NUM_REQ)  index of the requester being served.
- xfer_ack_i  in  1  destination acknowledge, already synchronized.
- timeout_o  out  1  one-cycle pulse on timeout; tied 0 when the feature is absent.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0. Reset asserted mid-transfer drops xfer_req_o immediately and no gnt_o is issued.
- States: IDLE, SETUP, REQ_HI, REQ_LO, DONE, plus DRAIN with the optional feature.
- IDLE:
  - If any req_i is set and xfer_ack_i==0, select a winner and go to SETUP.
  - The winner is the first set bit searching upward from the pointer, wrapping past NUM_REQ-1 to 0.
  - xfer_data_o and xfer_src_o load at that same edge.
  - If xfer_ack_i==1 (stale ack), stay in IDLE.
- SETUP: one cycle so the data is stable before the request. Next state REQ_HI; xfer_req_o rises at that edge.
- REQ_HI: hold until xfer_ack_i==1, then go to REQ_LO and drop xfer_req_o at that edge.
- REQ_LO: hold until xfer_ack_i==0, then go to DONE.
- DONE:
  - gnt_o[xfer_src_o]=1 for exactly this cycle.
  - Pointer becomes (xfer_src_o+1) mod NUM_REQ.
  - Next state IDLE.
- Latency: a request sampled in IDLE at cycle N gives xfer_req_o high from N+2. gnt_o is asserted 1 cycle after the sampled ack fall. Minimum total is 6 cycles with 1-cycle ack turnarounds.
- Requester contract:
  - A requester must drop req_i by the cycle after its gnt_o.
  - req_i still high in the following IDLE cycle is treated as a new request.
  - req_i dropped mid-transfer is ignored: the transfer completes and gnt_o is still pulsed.
- xfer_data_o and xfer_src_o change only on the IDLE->SETUP transition.
- Simultaneous requests: exactly one is served per transaction. Fairness guarantee: any continuously asserted request is served within NUM_REQ transactions.
- xfer_ack_i rising while in SETUP is treated as a protocol error and ignored (no state change).

Optional Feature:
- Macro: CDC_HS_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in REQ_HI.
  - If the counter reaches TIMEOUT_CYC-1 without an ack: drop xfer_req_o, pulse timeout_o, go to DRAIN.
  - DRAIN waits for xfer_ack_i==0 (no timeout) and then returns to IDLE.
  - No gnt_o is issued; the pointer advances past the failed requester.
  - The counter clears on every state entry.
- Without the macro: REQ_HI waits indefinitely, timeout_o is constant 0, and no counter or DRAIN state is synthesized.

Decomposition:
- Shared package/header cdc_hs_pkg contains:
  - State encodings (3-bit).
  - The clog2 function.
  - Default parameter constants.
- One sub-module, rr_arbiter: combinational NUM_REQ-way round-robin select from (req, pointer), producing a one-hot grant and an index.
- The FSM, registers and timeout counter stay in cdc_handshake_arbiter.

Test Plan:
- Single transfer: NUM_REQ=4, req_i=4'b0100, data2=8'hA5, ack returns 2 cycles after req and falls 2 cycles after req drops. Expect xfer_src_o=2, xfer_data_o=8'hA5, gnt_o=4'b0100 for 1 cycle, pointer=3.
- Round-robin: req_i=4'b1111 held (each requester re-asserting after its grant). Expect grant order 0,1,2,3,0, with busy_o low for exactly 1 cycle between transfers.
- Wrap: pointer=3 and req_i=4'b0011. Expect requester 0 served first, then 1.
- Stale ack: xfer_ack_i held 1 at reset release with req_i=4'b0001. Expect xfer_req_o to stay 0 until ack falls, then the transfer proceeds normally.
- Reset mid-REQ_HI: assert rst. Expect xfer_req_o=0 immediately, no gnt_o, pointer=0.
- Timeout (with CDC_HS_TIMEOUT_EN, TIMEOUT_CYC=16): ack never rises. Expect timeout_o pulse 16 cycles after xfer_req_o rises, xfer_req_o dropped, no gnt_o, next requester served.
